// File: rtl/mau_pkg.sv
// Shared encodings and lane helpers for the load/store access unit.
package mau_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    // WRITE owns bit 2 alone so the memory write enable is a bare flop output.
    localparam logic [2:0] ST_IDLE  = 3'b000;
    localparam logic [2:0] ST_READ  = 3'b001;
    localparam logic [2:0] ST_RESP  = 3'b010;
    localparam logic [2:0] ST_WRITE = 3'b100;

    function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] size,
                                                 input logic uns, input logic [1:0] lo);
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        sh = word >> {lo, 3'b000};
        b  = sh[7:0];
        h  = lo[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: res = {{24{~uns & b[7]}}, b};
            SZ_HALF: res = {{16{~uns & h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] word, input logic [31:0] wdata,
                                               input logic [1:0] size, input logic [1:0] lo);
        logic [31:0] res;
        res = word;
        if (size == SZ_BYTE) begin
            case (lo)
                2'd0:    res[7:0]   = wdata[7:0];
                2'd1:    res[15:8]  = wdata[7:0];
                2'd2:    res[23:16] = wdata[7:0];
                default: res[31:24] = wdata[7:0];
            endcase
        end else if (size == SZ_HALF) begin
            if (lo[1]) res[31:16] = wdata[15:0];
            else       res[15:0]  = wdata[15:0];
        end else begin
            res = wdata;
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Combinational lane logic: load extract/extend and sub-word store merge.
module mau_lane_align
    import mau_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [1:0]  lo,
    output logic [31:0] load_data,
    output logic [31:0] merged
);
    assign load_data = lane_extract(word, size, uns, lo);
    assign merged    = lane_merge(word, wdata, size, lo);
endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator for a word-wide data memory; sub-word stores via read-modify-write.
// Define MAU_MISALIGN_TRAP_EN to reject misaligned half/word accesses instead of ignoring low bits.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int MEM_WORDS = 256,
    parameter int ADDR_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);
    logic [2:0]        state;
    logic              r_we, r_uns;
    logic [1:0]        r_size, r_lo;
    logic [31:0]       r_wdata;
    logic [ADDR_W-1:0] req_idx;
    logic              req_err;
    logic [31:0]       load_data, merged;

    assign req_idx   = req_addr[ADDR_W+1:2];
    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign mem_we    = state[2];

    always_comb begin
        req_err = (req_size == SZ_RSVD) || (33'(req_idx) >= 33'(MEM_WORDS));
`ifdef MAU_MISALIGN_TRAP_EN
        if ((req_size == SZ_HALF && req_addr[0]) || (req_size == SZ_WORD && req_addr[1:0] != 2'b00))
            req_err = 1'b1;
`endif
    end

    mau_lane_align u_align (
        .word      (mem_rdata),
        .wdata     (r_wdata),
        .size      (r_size),
        .uns       (r_uns),
        .lo        (r_lo),
        .load_data (load_data),
        .merged    (merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            r_we      <= 1'b0;
            r_uns     <= 1'b0;
            r_size    <= SZ_BYTE;
            r_lo      <= 2'b00;
            r_wdata   <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                ST_IDLE: if (req_valid) begin
                    r_we      <= req_we;
                    r_uns     <= req_unsigned;
                    r_size    <= req_size;
                    r_lo      <= req_addr[1:0];
                    r_wdata   <= req_wdata;
                    mem_addr  <= req_idx;
                    rsp_rdata <= '0;
                    rsp_err   <= req_err;
                    if (req_we) mem_wdata <= req_wdata;
                    if (req_err)                          state <= ST_RESP;
                    else if (req_we && req_size == SZ_WORD) state <= ST_WRITE;
                    else                                  state <= ST_READ;
                end
                ST_READ: begin
                    if (r_we) begin
                        mem_wdata <= merged;
                        state     <= ST_WRITE;
                    end else begin
                        rsp_rdata <= load_data;
                        state     <= ST_RESP;
                    end
                end
                ST_WRITE: state <= ST_RESP;
                ST_RESP:  if (rsp_ready) state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end
endmodule
